// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller.
//   - intc_state_e : maskable request FSM states
//   - DEF_VECTOR_BASE / DEF_NMI_VECTOR : default RAM vector addresses
//   - VEC_STRIDE   : byte distance between consecutive maskable vectors
//   - vec_addr()   : vector address of a maskable source
package intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } intc_state_e;

    localparam logic [8:0] DEF_VECTOR_BASE = 9'h100;
    localparam logic [8:0] DEF_NMI_VECTOR  = 9'h1FC;
    localparam logic [8:0] VEC_STRIDE      = 9'd4;

    // Each maskable source owns one 4-byte slot above the base address.
    function automatic logic [8:0] vec_addr(input logic [8:0] base, input logic [8:0] idx);
        return base + (idx * VEC_STRIDE);
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Control-unit side bundle of the interrupt controller.
//   master : control unit (drives mask, enable, ack/eoi pulses; reads requests)
//   slave  : interrupt controller (drives requests, id, vector and pending status)
interface interrupt_controller_if #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 4
);
    logic               maskWrite;
    logic [NUM_IRQ-1:0] maskData;
    logic               globalEnable;
    logic               intAck;
    logic               nmiAck;
    logic               eoi;
    logic               hardwareInterrupt;
    logic               maskableInterrupt;
    logic [ID_W-1:0]    irqId;
    logic [8:0]         vectorAddr;
    logic [NUM_IRQ-1:0] pending;

    modport master (
        output maskWrite, maskData, globalEnable, intAck, nmiAck, eoi,
        input  hardwareInterrupt, maskableInterrupt, irqId, vectorAddr, pending
    );

    modport slave (
        input  maskWrite, maskData, globalEnable, intAck, nmiAck, eoi,
        output hardwareInterrupt, maskableInterrupt, irqId, vectorAddr, pending
    );
endinterface

// File: rtl/interrupt_controller_sync_edge.sv
// irq_sync_edge: two-flop synchroniser followed by a previous-value flop.
//   Clk    : system clock
//   reset  : asynchronous active-low reset
//   i_line : asynchronous input line
//   o_edge : one-cycle pulse when the synchronised line goes 0 -> 1
module irq_sync_edge (
    input  logic Clk,
    input  logic reset,
    input  logic i_line,
    output logic o_edge
);
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Synchronise the line and remember its previous synchronised value.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_edge = r_sync2 & ~r_prev;
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-latching interrupt controller with fixed priority.
//   Clk, reset : clock and asynchronous active-low reset
//   irqIn      : asynchronous maskable lines (rising edge requests)
//   nmiIn      : asynchronous non-maskable line (rising edge requests)
//   bus        : control-unit bundle (mask, enable, ack/eoi, requests, id, vector, pending)
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int         NUM_IRQ     = 8,
    parameter int         ID_W        = 4,
    parameter logic [8:0] VECTOR_BASE = DEF_VECTOR_BASE,
    parameter logic [8:0] NMI_VECTOR  = DEF_NMI_VECTOR
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irqIn,
    input  logic               nmiIn,
    interrupt_controller_if.slave bus
);
    intc_state_e        r_state;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic               r_nmi_pend;
    logic               r_maskable;
    logic [ID_W-1:0]    r_irq_id;
    logic [8:0]         r_vector;

    logic [NUM_IRQ-1:0] w_irq_edge;
    logic               w_nmi_edge;
    logic [NUM_IRQ-1:0] w_eligible;
    logic [ID_W-1:0]    w_win;
    logic [NUM_IRQ-1:0] w_id_onehot;
    logic               w_cur_ok;
    logic [NUM_IRQ-1:0] w_ack_clr;
    logic [NUM_IRQ-1:0] w_pending_nxt;
    logic               w_nmi_pend_nxt;
    logic [ID_W-1:0]    w_irq_id_nxt;

    // Lowest set index wins.
    function automatic logic [ID_W-1:0] prio_enc(input logic [NUM_IRQ-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = {ID_W{1'b0}};
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_irq_sync
        irq_sync_edge u_sync (
            .Clk    (Clk),
            .reset  (reset),
            .i_line (irqIn[g]),
            .o_edge (w_irq_edge[g])
        );
    end

    irq_sync_edge u_nmi_sync (
        .Clk    (Clk),
        .reset  (reset),
        .i_line (nmiIn),
        .o_edge (w_nmi_edge)
    );

    assign w_eligible  = bus.globalEnable ? (r_pending & r_mask) : {NUM_IRQ{1'b0}};
    assign w_win       = prio_enc(w_eligible);
    assign w_id_onehot = NUM_IRQ'(1'b1) << r_irq_id;
    // Still-valid test for the source currently being requested.
    assign w_cur_ok    = bus.globalEnable & (|(r_pending & r_mask & w_id_onehot));
    assign w_ack_clr   = ((r_state == ST_REQUEST) && bus.intAck) ? w_id_onehot : {NUM_IRQ{1'b0}};
    // Clear first, then OR in new edges so a same-cycle edge survives the ack.
    assign w_pending_nxt  = (r_pending & ~w_ack_clr) | w_irq_edge;
    assign w_nmi_pend_nxt = w_nmi_edge | (r_nmi_pend & ~bus.nmiAck);
    // Id the FSM will hold after this edge; the vector register follows it.
    assign w_irq_id_nxt   = ((r_state == ST_IDLE) && (|w_eligible)) ? w_win : r_irq_id;

    // Pending, mask, NMI pending and vector address registers.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_pending  <= {NUM_IRQ{1'b0}};
            r_mask     <= {NUM_IRQ{1'b0}};
            r_nmi_pend <= 1'b0;
            r_vector   <= VECTOR_BASE;
        end else begin
            r_pending  <= w_pending_nxt;
            r_mask     <= bus.maskWrite ? bus.maskData : r_mask;
            r_nmi_pend <= w_nmi_pend_nxt;
            r_vector   <= w_nmi_pend_nxt ? NMI_VECTOR : vec_addr(VECTOR_BASE, 9'(w_irq_id_nxt));
        end
    end

    // Maskable request FSM with registered request output and latched id.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_maskable <= 1'b0;
            r_irq_id   <= {ID_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_eligible) begin
                        r_state    <= ST_REQUEST;
                        r_maskable <= 1'b1;
                        r_irq_id   <= w_win;
                    end else begin
                        r_maskable <= 1'b0;
                    end
                end
                ST_REQUEST: begin
                    if (bus.intAck) begin
                        r_state    <= ST_SERVICE;
                        r_maskable <= 1'b0;
                    end else if (!w_cur_ok) begin
                        // Request withdrawn; pending is kept and re-arbitrated from IDLE.
                        r_state    <= ST_IDLE;
                        r_maskable <= 1'b0;
                    end else begin
                        r_maskable <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    r_maskable <= 1'b0;
                    if (bus.eoi) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_SERVICE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_maskable <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hardwareInterrupt = r_nmi_pend;
    assign bus.maskableInterrupt = r_maskable;
    assign bus.irqId             = r_irq_id;
    assign bus.vectorAddr        = r_vector;
    assign bus.pending           = r_pending;
endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Upstream neighbour of `data_path`. It synchronises external interrupt lines, latches rising edges into a pending register, and applies a CU-writable mask and a global enable. It resolves fixed priority and drives `data_path`'s `hardwareInterrupt` (non-maskable) and `maskableInterrupt` inputs. For the CU trap sequence it supplies the source id and a 9-bit RAM vector address sized for the trap mux. Request, acknowledge and end-of-interrupt follow a strict handshake.

## Interface
- NUM_IRQ, 8: number of maskable sources, 1..16.
- ID_W, 4: width of `irqId`.
- VECTOR_BASE, 9'h100: RAM address of the vector for source 0.
- NMI_VECTOR, 9'h1FC: RAM address of the non-maskable vector.
- Clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- irqIn  in  NUM_IRQ  asynchronous maskable lines; rising edge requests.
- nmiIn  in  1  asynchronous non-maskable line; rising edge requests.
- maskWrite  in  1  one-cycle pulse from CU; loads `maskData`.
- maskData  in  NUM_IRQ  new mask; bit=1 enables the source.
- globalEnable  in  1  CU status-register interrupt enable (level).
- intAck  in  1  one-cycle pulse; CU has accepted the maskable request.
- nmiAck  in  1  one-cycle pulse; CU has accepted the NMI.
- eoi  in  1  one-cycle pulse; maskable handler finished.
- hardwareInterrupt  out  1  NMI request to `data_path`.
- maskableInterrupt  out  1  maskable request to `data_path`.
- irqId  out  ID_W  latched source id, valid while the FSM is in REQUEST or SERVICE.
- vectorAddr  out  9  trap address: NMI_VECTOR while an NMI is pending, else VECTOR_BASE + {irqId,2'b00}.
- pending  out  NUM_IRQ  pending register, for debug/status reads.

## Operation
- Each line has a 2-flop synchroniser, then a previous-value flop. Edge = sync2 & ~prev.
- Edge detected on line i: pending[i] <= 1.
- intAck while in REQUEST clears pending[irqId].
  - If a new edge on that same line arrives in the same cycle, the set wins and pending stays 1.
- NMI path is independent of mask, globalEnable and FSM state:
  - nmiPend is set on an nmiIn edge and cleared by nmiAck; a set in the same cycle wins.
  - hardwareInterrupt = nmiPend (registered).
- Mask register: maskWrite loads the mask the next edge. Writing the mask does not clear pending bits.
- Eligible vector: pending & mask, gated by globalEnable. Priority is fixed, lowest index highest.
- Maskable FSM states: IDLE, REQUEST, SERVICE.
  - IDLE -> REQUEST when the eligible vector is nonzero. irqId latches the winning index.
  - REQUEST -> SERVICE on intAck.
  - REQUEST -> IDLE if pending[irqId]&mask[irqId]&globalEnable falls. pending is retained; the next decision re-arbitrates.
  - SERVICE -> IDLE on eoi. No nesting: a higher-priority edge during SERVICE only sets pending.
  - intAck outside REQUEST and eoi outside SERVICE are ignored.
- maskableInterrupt = (state==REQUEST), registered, not combinational.
- Reset (asynchronous, any state) clears all of the following:
  - synchroniser and prev flops, pending, nmiPend and mask;
  - state returns to IDLE;
  - irqId = 0, hardwareInterrupt = 0, maskableInterrupt = 0;
  - vectorAddr = VECTOR_BASE, pending = 0.

## Timing
- irqIn rises before Clk edge k: pending set at k+2; FSM enters REQUEST and maskableInterrupt rises at k+3.
- nmiIn rises before edge k: hardwareInterrupt rises at k+2.
- intAck at edge j: maskableInterrupt low and pending bit cleared after j. Earliest next REQUEST is one cycle after eoi.
- nmiAck at edge j: hardwareInterrupt low after j.
- Lines must be held high at least 3 cycles to be guaranteed edge-detected.
- vectorAddr and irqId are stable from the REQUEST entry edge until intAck/nmiAck.

## Structure
- `intc_pkg` holds:
  - the FSM state enum (IDLE/REQUEST/SERVICE);
  - default VECTOR_BASE and NMI_VECTOR;
  - the vector stride constant (4 bytes).
- Sub-module `irq_sync_edge`: synchroniser plus edge detector, one instance per line including NMI.
- The priority encoder is a function inside the top module.

## Test plan
- Reset low, then release: all outputs 0, vectorAddr=9'h100. maskWrite 8'h04, then irqIn[2] pulse: maskableInterrupt rises 3 edges later, irqId=2, vectorAddr=9'h108.
- irqIn[5] and irqIn[1] rise together, mask=8'hFF: irqId=1 first. After intAck+eoi, irqId=5 with vectorAddr=9'h114.
- irqIn[3] while mask bit 3=0: pending[3]=1, no request. Set mask bit 3: request appears the next cycle.
- In REQUEST, globalEnable drops: maskableInterrupt falls, FSM returns to IDLE, pending kept. Re-enable: request reasserts.
- nmiIn edge during SERVICE: hardwareInterrupt=1 and vectorAddr=9'h1FC. nmiAck clears it; SERVICE state is unchanged.
- Edge on the acknowledged line in the intAck cycle: pending stays 1. A reset pulse mid-REQUEST clears everything immediately, without waiting for Clk.
